// File: rtl/vgpr_rd_port_arbiter_pkg.sv
// rtl/vgpr_rd_port_arbiter_pkg.sv - shared VGPR global/issue definitions
package vgpr_rd_port_arbiter_pkg;

    localparam int VGPR_ADDR_W = 10;
    localparam int VGPR_DATA_W = 2048;
    localparam int PORT_SEL_W  = 16;
    localparam int MAX_PORTS   = 8;

    localparam logic [PORT_SEL_W-1:0] PORT_SEL_IDLE = 16'h0000;

    // Travels alongside each issued read so the row can be routed back.
    typedef struct packed {
        logic       valid;
        logic [2:0] port;
    } rd_tag_t;

endpackage

// File: rtl/vgpr_rd_port_arbiter_if.sv
// rtl/vgpr_rd_port_arbiter_if.sv - requester-side request/response bundle
interface vgpr_rd_port_arbiter_if
    import vgpr_rd_port_arbiter_pkg::*;
#(
    parameter int NUM_PORTS = MAX_PORTS,
    parameter int ADDR_W    = VGPR_ADDR_W,
    parameter int DATA_W    = VGPR_DATA_W
);
    logic [NUM_PORTS-1:0]        req_valid;
    logic [NUM_PORTS*ADDR_W-1:0] req_addr;
    logic [NUM_PORTS-1:0]        req_ready;
    logic [NUM_PORTS-1:0]        rsp_valid;
    logic [DATA_W-1:0]           rsp_data;

    modport master (
        output req_valid, req_addr,
        input  req_ready, rsp_valid, rsp_data
    );

    modport slave (
        input  req_valid, req_addr,
        output req_ready, rsp_valid, rsp_data
    );
endinterface

// File: rtl/vgpr_rd_port_arbiter_rr_arbiter_8.sv
// rtl/vgpr_rd_port_arbiter_rr_arbiter_8.sv - round-robin pointer and masked priority encoder
module rr_arbiter_8
    import vgpr_rd_port_arbiter_pkg::*;
#(
    parameter int NUM_PORTS = MAX_PORTS
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_PORTS-1:0] req,
    output logic [NUM_PORTS-1:0] grant,
    output logic [2:0]           grant_idx,
    output logic                 grant_valid
);

    logic [2:0] ptr;
    logic [3:0] sum;
    logic [2:0] cand;

    // Walk from the pointer upward, wrapping at NUM_PORTS; first hit wins.
    always_comb begin
        grant       = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        sum         = '0;
        cand        = '0;
        if (!rst) begin
            for (int k = 0; k < NUM_PORTS; k++) begin
                sum = {1'b0, ptr} + 4'(k);
                if (sum >= 4'(NUM_PORTS)) begin
                    sum = sum - 4'(NUM_PORTS);
                end
                cand = sum[2:0];
                if (!grant_valid && req[cand]) begin
                    grant_valid = 1'b1;
                    grant_idx   = cand;
                end
            end
            if (grant_valid) begin
                grant[grant_idx] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= '0;
        end else if (grant_valid) begin
            ptr <= (grant_idx == 3'(NUM_PORTS - 1)) ? 3'd0 : grant_idx + 3'd1;
        end
    end

endmodule

// File: rtl/vgpr_rd_port_arbiter.sv
// rtl/vgpr_rd_port_arbiter.sv - arbitrates requesters onto the single VGPR read port and routes rows back
module vgpr_rd_port_arbiter
    import vgpr_rd_port_arbiter_pkg::*;
#(
    parameter int NUM_PORTS  = MAX_PORTS,
    parameter int ADDR_W     = VGPR_ADDR_W,
    parameter int DATA_W     = VGPR_DATA_W,
    parameter int RD_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    vgpr_rd_port_arbiter_if.slave req_if,
    output logic [PORT_SEL_W-1:0] rd_port_select,
    output logic                  rf_rd_en,
    output logic [ADDR_W-1:0]     rf_rd_addr,
    input  logic [DATA_W-1:0]     rf_rd_data
);

    logic [NUM_PORTS-1:0] grant;
    logic [2:0]           grant_idx;
    logic                 grant_valid;
    rd_tag_t              issue_tag;
    rd_tag_t              tag_pipe [RD_LATENCY];
    rd_tag_t              tag_last;

    rr_arbiter_8 #(
        .NUM_PORTS (NUM_PORTS)
    ) u_rr_arbiter_8 (
        .clk         (clk),
        .rst         (rst),
        .req         (req_if.req_valid),
        .grant       (grant),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid)
    );

    assign req_if.req_ready = grant;
    assign rd_port_select   = PORT_SEL_IDLE | PORT_SEL_W'(grant);

    // Any grant is a transfer since grants only go to valid requesters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            issue_tag  <= '0;
            rf_rd_addr <= '0;
        end else begin
            issue_tag <= '{valid: grant_valid, port: grant_idx};
            if (grant_valid) begin
                rf_rd_addr <= req_if.req_addr[int'(grant_idx)*ADDR_W +: ADDR_W];
            end
        end
    end

    assign rf_rd_en = issue_tag.valid;

    // Tag rides alongside the RAM access so it surfaces with the row.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < RD_LATENCY; s++) begin
                tag_pipe[s] <= '0;
            end
        end else begin
            tag_pipe[0] <= issue_tag;
            for (int s = 1; s < RD_LATENCY; s++) begin
                tag_pipe[s] <= tag_pipe[s-1];
            end
        end
    end

    assign tag_last = tag_pipe[RD_LATENCY-1];

    always_comb begin
        req_if.rsp_valid = '0;
        if (tag_last.valid) begin
            req_if.rsp_valid[tag_last.port] = 1'b1;
        end
    end

    assign req_if.rsp_data = rf_rd_data;

endmodule

// File: tb/tb_vgpr_rd_port_arbiter.sv
// tb/tb_vgpr_rd_port_arbiter.sv - self-checking bench for vgpr_rd_port_arbiter at read latencies 1 and 3
module tb_vgpr_rd_port_arbiter;
    import vgpr_rd_port_arbiter_pkg::*;

    localparam int NP = 8;
    localparam int AW = 10;
    localparam int DW = 2048;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    vgpr_rd_port_arbiter_if #(.NUM_PORTS(NP), .ADDR_W(AW), .DATA_W(DW)) if1 ();
    vgpr_rd_port_arbiter_if #(.NUM_PORTS(NP), .ADDR_W(AW), .DATA_W(DW)) if3 ();

    assign if3.req_valid = if1.req_valid;
    assign if3.req_addr  = if1.req_addr;

    logic [15:0]   sel1, sel3;
    logic          en1, en3;
    logic [AW-1:0] raddr1, raddr3;
    logic [DW-1:0] rdata1, rdata3;

    vgpr_rd_port_arbiter #(.NUM_PORTS(NP), .ADDR_W(AW), .DATA_W(DW), .RD_LATENCY(1)) u_dut_l1 (
        .clk(clk), .rst(rst), .req_if(if1), .rd_port_select(sel1),
        .rf_rd_en(en1), .rf_rd_addr(raddr1), .rf_rd_data(rdata1)
    );

    vgpr_rd_port_arbiter #(.NUM_PORTS(NP), .ADDR_W(AW), .DATA_W(DW), .RD_LATENCY(3)) u_dut_l3 (
        .clk(clk), .rst(rst), .req_if(if3), .rd_port_select(sel3),
        .rf_rd_en(en3), .rf_rd_addr(raddr3), .rf_rd_data(rdata3)
    );

    // Row content is a pure function of the address so misrouted reads show up.
    function automatic logic [DW-1:0] row(input logic [AW-1:0] a);
        logic [15:0] mix;
        for (int j = 0; j < 64; j++) begin
            mix = 16'(a) * 16'd97 + 16'(j);
            row[j*32 +: 32] = {a, 6'(j), mix};
        end
    endfunction

    // VGPR file stand-in: row for the address presented RD_LATENCY edges ago.
    logic [AW-1:0] m1;
    logic [AW-1:0] m3 [3];
    always @(posedge clk) begin
        m3[2] = m3[1];
        m3[1] = m3[0];
        m3[0] = raddr3;
        m1    = raddr1;
        rdata1 = row(m1);
        rdata3 = row(m3[2]);
    end

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: pointer plus per-cycle history of winners and their addresses.
    int            ptr;
    int            cur_gnt;
    logic [AW-1:0] cur_addr;
    int            gh[$];
    logic [AW-1:0] ah[$];
    logic [AW-1:0] model_rd_addr;

    logic [7:0]    exp_ready, exp_rsp1, exp_rsp3;
    logic [15:0]   exp_sel;
    logic          exp_en;
    logic [AW-1:0] exp_raddr;
    logic [DW-1:0] exp_d1, exp_d3;

    task automatic model_reset();
        ptr = 0;
        cur_gnt = -1;
        cur_addr = '0;
        model_rd_addr = '0;
        gh = {};
        ah = {};
        repeat (4) begin
            gh.push_back(-1);
            ah.push_back('0);
        end
    endtask

    // Closes the previous cycle at the edge, applies new inputs, returns mid-cycle.
    task automatic drive(input logic [7:0] v, input logic [NP*AW-1:0] a);
        int n;
        @(posedge clk);
        gh.push_back(cur_gnt);
        ah.push_back(cur_addr);
        if (cur_gnt >= 0) begin
            ptr = (cur_gnt + 1) % NP;
            model_rd_addr = cur_addr;
        end
        while (gh.size() > 8) begin
            void'(gh.pop_front());
            void'(ah.pop_front());
        end
        #1;
        if1.req_valid = v;
        if1.req_addr  = a;
        cur_gnt = -1;
        for (int k = 0; k < NP; k++) begin
            if (cur_gnt < 0 && v[(ptr + k) % NP]) cur_gnt = (ptr + k) % NP;
        end
        cur_addr  = (cur_gnt >= 0) ? a[cur_gnt*AW +: AW] : '0;
        exp_ready = (cur_gnt >= 0) ? 8'(1 << cur_gnt) : 8'h00;
        exp_sel   = {8'h00, exp_ready};
        n = gh.size();
        exp_en    = (gh[n-1] >= 0);
        exp_raddr = model_rd_addr;
        exp_rsp1  = (gh[n-2] >= 0) ? 8'(1 << gh[n-2]) : 8'h00;
        exp_d1    = row(ah[n-2]);
        exp_rsp3  = (gh[n-4] >= 0) ? 8'(1 << gh[n-4]) : 8'h00;
        exp_d3    = row(ah[n-4]);
        @(negedge clk);
    endtask

    function automatic logic [NP*AW-1:0] rand_addrs();
        logic [NP*AW-1:0] a;
        for (int p = 0; p < NP; p++) a[p*AW +: AW] = AW'($urandom);
        return a;
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        if1.req_valid = '0;
        if1.req_addr  = '0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        model_reset();
        if1.req_valid = 8'hFF;
        if1.req_addr  = rand_addrs();
        @(negedge clk);
        n_cmp++; if (if1.req_ready !== 8'h00) begin n_bad++; $display("FAIL reset_ready got %h want 00", if1.req_ready); end
        n_cmp++; if (sel1 !== 16'h0000) begin n_bad++; $display("FAIL reset_sel got %h want 0000", sel1); end
        n_cmp++; if (en1 !== 1'b0 || en3 !== 1'b0) begin n_bad++; $display("FAIL reset_en got %b%b want 00", en1, en3); end
        n_cmp++; if (raddr1 !== '0 || raddr3 !== '0) begin n_bad++; $display("FAIL reset_addr got %h/%h want 0", raddr1, raddr3); end
        n_cmp++; if (if1.rsp_valid !== 8'h00 || if3.rsp_valid !== 8'h00) begin n_bad++; $display("FAIL reset_rsp got %h/%h want 00", if1.rsp_valid, if3.rsp_valid); end
        if1.req_valid = '0;
        rst = 1'b0;
    endtask

    task automatic test_single();
        logic [NP*AW-1:0] a;
        do_reset();
        a = rand_addrs();
        a[2*AW +: AW] = 10'h155;
        drive(8'h04, a);
        n_cmp++; if (if1.req_ready !== 8'h04) begin n_bad++; $display("FAIL single_ready got %h want 04", if1.req_ready); end
        n_cmp++; if (sel1 !== 16'h0004) begin n_bad++; $display("FAIL single_sel got %h want 0004", sel1); end
        drive(8'h00, rand_addrs());
        n_cmp++; if (en1 !== 1'b1 || raddr1 !== 10'h155) begin n_bad++; $display("FAIL single_issue got en=%b addr=%h want en=1 addr=155", en1, raddr1); end
        drive(8'h00, rand_addrs());
        n_cmp++; if (if1.rsp_valid !== 8'h04) begin n_bad++; $display("FAIL single_rsp got %h want 04", if1.rsp_valid); end
        n_cmp++; if (if1.rsp_data !== row(10'h155)) begin n_bad++; $display("FAIL single_data got %h want %h", if1.rsp_data[31:0], row(10'h155) & 32'hFFFFFFFF); end
        drive(8'h00, rand_addrs());
        drive(8'h00, rand_addrs());
        n_cmp++; if (if3.rsp_valid !== 8'h04 || if3.rsp_data !== row(10'h155)) begin n_bad++; $display("FAIL single_rsp_l3 got %h want 04", if3.rsp_valid); end
    endtask

    task automatic test_all_valid();
        do_reset();
        for (int c = 0; c < 16; c++) begin
            drive(8'hFF, rand_addrs());
            n_cmp++; if (if1.req_ready !== 8'(1 << (c % 8)) || if1.req_ready !== exp_ready) begin n_bad++; $display("FAIL rotate_ready c%0d got %h want %h", c, if1.req_ready, exp_ready); end
            if (c > 0) begin
                n_cmp++; if (en1 !== 1'b1 || raddr1 !== exp_raddr) begin n_bad++; $display("FAIL rotate_issue c%0d got en=%b addr=%h want en=1 addr=%h", c, en1, raddr1, exp_raddr); end
            end
        end
    endtask

    task automatic test_wrap();
        do_reset();
        drive(8'h80, rand_addrs());
        n_cmp++; if (if1.req_ready !== 8'h80) begin n_bad++; $display("FAIL wrap_p7 got %h want 80", if1.req_ready); end
        drive(8'h81, rand_addrs());
        n_cmp++; if (if1.req_ready !== 8'h01) begin n_bad++; $display("FAIL wrap_p0 got %h want 01", if1.req_ready); end
        drive(8'h81, rand_addrs());
        n_cmp++; if (if1.req_ready !== 8'h80 || sel3 !== 16'h0080) begin n_bad++; $display("FAIL wrap_p7_again got %h/%h want 80/0080", if1.req_ready, sel3); end
    endtask

    task automatic test_latency3();
        logic [NP*AW-1:0] a0, a1;
        do_reset();
        a0 = rand_addrs();
        a1 = rand_addrs();
        drive(8'h02, a0);
        drive(8'h20, a1);
        for (int c = 2; c < 6; c++) begin
            drive(8'h00, rand_addrs());
            if (c == 2 || c == 3) begin
                n_cmp++; if (if1.rsp_valid !== ((c == 2) ? 8'h02 : 8'h20) || if1.rsp_data !== row((c == 2) ? a0[1*AW +: AW] : a1[5*AW +: AW])) begin n_bad++; $display("FAIL lat1_rsp c%0d got %h", c, if1.rsp_valid); end
            end
            if (c == 4 || c == 5) begin
                n_cmp++; if (if3.rsp_valid !== ((c == 4) ? 8'h02 : 8'h20)) begin n_bad++; $display("FAIL lat3_rsp c%0d got %h want %h", c, if3.rsp_valid, (c == 4) ? 8'h02 : 8'h20); end
                n_cmp++; if (if3.rsp_data !== row((c == 4) ? a0[1*AW +: AW] : a1[5*AW +: AW])) begin n_bad++; $display("FAIL lat3_data c%0d got %h", c, if3.rsp_data[31:0]); end
            end
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        drive(8'h08, rand_addrs());
        drive(8'h00, rand_addrs());
        n_cmp++; if (en1 !== 1'b1 || en3 !== 1'b1) begin n_bad++; $display("FAIL areset_pre got %b%b want 11", en1, en3); end
        #2 rst = 1'b1;
        model_reset();
        #1;
        n_cmp++; if (en1 !== 1'b0 || en3 !== 1'b0) begin n_bad++; $display("FAIL areset_en got %b%b want 00", en1, en3); end
        n_cmp++; if (if1.rsp_valid !== 8'h00 || if3.rsp_valid !== 8'h00) begin n_bad++; $display("FAIL areset_rsp got %h/%h want 00", if1.rsp_valid, if3.rsp_valid); end
        @(posedge clk);
        #3 rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            drive(8'h00, rand_addrs());
            n_cmp++; if (if1.rsp_valid !== 8'h00 || if3.rsp_valid !== 8'h00) begin n_bad++; $display("FAIL areset_ghost c%0d got %h/%h want 00", c, if1.rsp_valid, if3.rsp_valid); end
        end
        drive(8'h24, rand_addrs());
        n_cmp++; if (if1.req_ready !== 8'h04 || if1.req_ready !== exp_ready) begin n_bad++; $display("FAIL areset_ptr got %h want 04", if1.req_ready); end
    endtask

    task automatic test_idle();
        logic [NP*AW-1:0] a;
        do_reset();
        a = rand_addrs();
        drive(8'h08, a);
        for (int c = 0; c < 10; c++) begin
            drive(8'h00, rand_addrs());
            n_cmp++; if (if1.req_ready !== 8'h00 || sel1 !== 16'h0000) begin n_bad++; $display("FAIL idle_grant c%0d got %h/%h want 00/0000", c, if1.req_ready, sel1); end
            n_cmp++; if (raddr1 !== a[3*AW +: AW] || raddr3 !== a[3*AW +: AW]) begin n_bad++; $display("FAIL idle_addr c%0d got %h want %h", c, raddr1, a[3*AW +: AW]); end
            if (c > 0) begin
                n_cmp++; if (en1 !== 1'b0 || en3 !== 1'b0) begin n_bad++; $display("FAIL idle_en c%0d got %b%b want 00", c, en1, en3); end
            end
        end
    endtask

    task automatic test_random();
        logic [7:0] v;
        do_reset();
        for (int c = 0; c < 300; c++) begin
            v = 8'($urandom);
            if ($urandom_range(0, 3) == 0) v = 8'h00;
            drive(v, rand_addrs());
            n_cmp++; if (if1.req_ready !== exp_ready || if3.req_ready !== exp_ready) begin n_bad++; $display("FAIL rand_ready c%0d got %h/%h want %h", c, if1.req_ready, if3.req_ready, exp_ready); end
            n_cmp++; if (sel1 !== exp_sel || sel3 !== exp_sel) begin n_bad++; $display("FAIL rand_sel c%0d got %h/%h want %h", c, sel1, sel3, exp_sel); end
            n_cmp++; if (en1 !== exp_en || en3 !== exp_en) begin n_bad++; $display("FAIL rand_en c%0d got %b%b want %b", c, en1, en3, exp_en); end
            n_cmp++; if (raddr1 !== exp_raddr || raddr3 !== exp_raddr) begin n_bad++; $display("FAIL rand_addr c%0d got %h/%h want %h", c, raddr1, raddr3, exp_raddr); end
            n_cmp++; if (if1.rsp_valid !== exp_rsp1) begin n_bad++; $display("FAIL rand_rsp1 c%0d got %h want %h", c, if1.rsp_valid, exp_rsp1); end
            n_cmp++; if (if3.rsp_valid !== exp_rsp3) begin n_bad++; $display("FAIL rand_rsp3 c%0d got %h want %h", c, if3.rsp_valid, exp_rsp3); end
            if (exp_rsp1 != 8'h00) begin
                n_cmp++; if (if1.rsp_data !== exp_d1) begin n_bad++; $display("FAIL rand_data1 c%0d got %h want %h", c, if1.rsp_data[31:0], exp_d1[31:0]); end
            end
            if (exp_rsp3 != 8'h00) begin
                n_cmp++; if (if3.rsp_data !== exp_d3) begin n_bad++; $display("FAIL rand_data3 c%0d got %h want %h", c, if3.rsp_data[31:0], exp_d3[31:0]); end
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: run exceeded time limit");
        $fatal(1);
    end

    initial begin
        if1.req_valid = '0;
        if1.req_addr  = '0;
        test_reset();
        test_single();
        test_all_valid();
        test_wrap();
        test_latency3();
        test_async_reset();
        test_idle();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
